// File: rtl/neuron_core.sv
`default_nettype none
// ============================================================================
//  Module   : neuron_core
//  Purpose  : Two-input perceptron neuron in a Tiny-Tapeout style pin wrapper.
//             Computes sum = w0*x0 + w1*x1 + bias using signed 5-bit weights
//             and unsigned 4-bit inputs. It registers a fire bit
//             (sum >= thr) and a copy of the sum saturated to 0..127.
//             Weights, bias and threshold are written at runtime through
//             the uio bus.
//  Ports    :
//    clk      in   1  rising-edge clock
//    rst_n    in   1  synchronous reset, ACTIVE-HIGH despite the name
//    ena      in   1  design select, no functional effect
//    ui_in    in   8  [3:0]=x0, [7:4]=x1 (unsigned)
//    uio_in   in   8  [7]=write enable, [6:5]=address, [4:0]=signed data
//    uo_out   out  8  [0]=fire, [7:1]=saturated sum (registered)
//    uio_out  out  8  tied to 0
//    uio_oe   out  8  tied to 0 (uio pins are inputs only)
//  Revision : 1.0 - initial release
// ============================================================================
module neuron_core #(
  parameter logic signed [4:0] W0_RST   = 5'sd1,
  parameter logic signed [4:0] W1_RST   = 5'sd1,
  parameter logic signed [4:0] BIAS_RST = 5'sd0,
  parameter logic signed [4:0] THR_RST  = 5'sd1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [1:0] c_ADDR_W0   = 2'd0;
  localparam logic [1:0] c_ADDR_W1   = 2'd1;
  localparam logic [1:0] c_ADDR_THR  = 2'd2;
  localparam logic [1:0] c_ADDR_BIAS = 2'd3;

  // Configuration registers
  logic signed [4:0] w0_q,   w0_d;
  logic signed [4:0] w1_q,   w1_d;
  logic signed [4:0] thr_q,  thr_d;
  logic signed [4:0] bias_q, bias_d;

  // Output register
  logic [7:0] uo_q, uo_d;

  // Datapath
  logic signed [8:0] w_p0;
  logic signed [8:0] w_p1;
  logic signed [9:0] w_sum;
  logic              w_fire;
  logic [6:0]        w_sat;

  logic       w_wr_en;
  logic [1:0] w_wr_addr;
  logic [4:0] w_wr_data;

  assign w_wr_en   = uio_in[7];
  assign w_wr_addr = uio_in[6:5];
  assign w_wr_data = uio_in[4:0];

  // Zero-extend the unsigned inputs before the signed multiply so that
  // x=15 is not read as -1. Every operand is widened to 9 bits, and the
  // products fit in that width.
  assign w_p0  = 9'(signed'({1'b0, ui_in[3:0]})) * 9'(w0_q);
  assign w_p1  = 9'(signed'({1'b0, ui_in[7:4]})) * 9'(w1_q);
  assign w_sum = 10'(w_p0) + 10'(w_p1) + 10'(bias_q);

  assign w_fire = (w_sum >= 10'(thr_q));

  always_comb begin
    w_sat = w_sum[6:0];
    if (w_sum[9]) begin
      w_sat = 7'd0;
    end else if (w_sum[8:7] != 2'b00) begin
      w_sat = 7'd127;
    end
  end

  // Next-state: the write decode only applies outside reset. Reset
  // priority is handled in the register process.
  always_comb begin
    w0_d   = w0_q;
    w1_d   = w1_q;
    thr_d  = thr_q;
    bias_d = bias_q;
    uo_d   = {w_sat, w_fire};
    if (w_wr_en) begin
      case (w_wr_addr)
        c_ADDR_W0:   w0_d   = w_wr_data;
        c_ADDR_W1:   w1_d   = w_wr_data;
        c_ADDR_THR:  thr_d  = w_wr_data;
        c_ADDR_BIAS: bias_d = w_wr_data;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      w0_q   <= W0_RST;
      w1_q   <= W1_RST;
      thr_q  <= THR_RST;
      bias_q <= BIAS_RST;
      uo_q   <= 8'h00;
    end else begin
      w0_q   <= w0_d;
      w1_q   <= w1_d;
      thr_q  <= thr_d;
      bias_q <= bias_d;
      uo_q   <= uo_d;
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  // ena is part of the standard pin set but has no function here.
  logic unused_ena;
  assign unused_ena = ena;

endmodule
`default_nettype wire

// File: tb/tb_neuron_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_neuron_core
//  Purpose  : Directed self-checking bench for neuron_core. Expected values
//             are hand-computed constants.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_neuron_core;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks;
  int n_pass;

  neuron_core dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    if (obs === exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 8'h%02h expected 8'h%02h", tag, obs, exp_v);
    end
  endtask

  // Inputs change 1 time unit after a rising edge, and outputs are sampled
  // at the same point. That keeps both away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the output in the expected packing {sat, fire}. It also checks
  // that the uio pins stay tied low.
  task automatic expect_out(input string tag, input logic [6:0] sat, input logic fire);
    check(tag, uo_out, {sat, fire});
    check({tag, "_uio_out"}, uio_out, 8'h00);
    check({tag, "_uio_oe"}, uio_oe, 8'h00);
  endtask

  task automatic write_cfg(input logic [1:0] addr, input logic [4:0] data);
    uio_in = {1'b1, addr, data};
    tick();
    uio_in = 8'h00;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    ena      = 1'b1;
    rst_n    = 1'b1;
    ui_in    = 8'h00;
    uio_in   = 8'h00;

    // Reset for 2 cycles. A write attempted during reset must be ignored.
    tick();
    uio_in = {1'b1, 2'b00, 5'b10000};   // attempt w0=-16 during reset
    tick();
    uio_in = 8'h00;
    expect_out("reset", 7'd0, 1'b0);

    // Defaults: w0=w1=1, bias=0, thr=1
    rst_n = 1'b0;
    ui_in = 8'h11; tick(); expect_out("def_11", 7'd2, 1'b1);
    ui_in = 8'h22; tick(); expect_out("def_22", 7'd4, 1'b1);
    ui_in = 8'h44; tick(); expect_out("def_44", 7'd8, 1'b1);
    ui_in = 8'h00; tick(); expect_out("def_00", 7'd0, 1'b0);

    // Config writes: w0=-3, w1=2, thr=5
    write_cfg(2'b00, 5'b11101);
    write_cfg(2'b01, 5'b00010);
    write_cfg(2'b10, 5'b00101);
    ui_in = 8'h41; tick(); expect_out("cfg_sum5_eq_thr", 7'd5, 1'b1);   // -3+8=5
    ui_in = 8'h43; tick(); expect_out("cfg_sum_neg1", 7'd0, 1'b0);      // -9+8=-1
    ui_in = 8'h42; tick(); expect_out("cfg_sum2_lt_thr", 7'd2, 1'b0);   // -6+8=2

    // Saturation high: w0=w1=15, x=15 -> 450
    write_cfg(2'b00, 5'b01111);
    write_cfg(2'b01, 5'b01111);
    ui_in = 8'hFF; tick(); expect_out("sat_high", 7'd127, 1'b1);
    ui_in = 8'h44; tick(); expect_out("sat_mid_120", 7'd120, 1'b1);     // 60+60
    ui_in = 8'h54; tick(); expect_out("sat_edge_135", 7'd127, 1'b1);    // 60+75

    // Saturation low: w0=w1=-16, x=15 -> -480
    write_cfg(2'b00, 5'b10000);
    write_cfg(2'b01, 5'b10000);
    ui_in = 8'hFF; tick(); expect_out("sat_low", 7'd0, 1'b0);

    // Reset back to defaults for the bias test
    rst_n = 1'b1; tick();
    expect_out("reset2", 7'd0, 1'b0);
    rst_n = 1'b0;

    // A same-edge bias write must still produce output from the old config.
    ui_in  = 8'h11;
    uio_in = {1'b1, 2'b11, 5'b11110};   // bias=-2
    tick();
    uio_in = 8'h00;
    expect_out("same_edge_old_cfg", 7'd2, 1'b1);
    tick();
    expect_out("bias_applied", 7'd0, 1'b0);                             // 1+1-2=0 < 1

    // Reset in the middle of operation, with a modified config
    ui_in = 8'h22; tick(); expect_out("pre_reset_fire", 7'd2, 1'b1);    // 2+2-2=2
    rst_n = 1'b1; tick();
    expect_out("mid_reset", 7'd0, 1'b0);
    rst_n = 1'b0;
    ui_in = 8'h11; tick(); expect_out("defaults_restored", 7'd2, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
